input_port: RTL

- Receive side of a router link. Accepts 32-bit flits from a neighbour's output port with a valid/ready handshake and buffers them in a small FIFO.
- Decodes the head flit's destination with XY routing and requests one output direction from the switch arbiter.
- Forwards the packet wormhole-style, one flit per granted cycle, until the tail flit leaves.
- Sits between a link and the crossbar, one instance per router input (local, N, E, S, W).

---
 rtl/noc_pkg.sv | 41 ++++
 rtl/input_port_sync_fifo.sv | 54 +++++
 rtl/input_port.sv | 104 ++++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit types, port directions and
// the input-port FSM states, plus the XY routing function.
package noc_pkg;

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_t;

  localparam logic [2:0] DIR_L = 3'd0;
  localparam logic [2:0] DIR_N = 3'd1;
  localparam logic [2:0] DIR_E = 3'd2;
  localparam logic [2:0] DIR_S = 3'd3;
  localparam logic [2:0] DIR_W = 3'd4;

  localparam int unsigned FLIT_W   = 32;
  localparam int unsigned TYPE_MSB = 31;
  localparam int unsigned TYPE_LSB = 30;
  localparam int unsigned DEST_MSB = 29;
  localparam int unsigned DEST_LSB = 26;
  localparam int unsigned SRC_MSB  = 25;
  localparam int unsigned SRC_LSB  = 22;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_FWD
  } ip_state_t;

  // X dimension is resolved first; y is only compared once x matches.
  function automatic logic [2:0] xy_route(input logic [3:0] dest, input logic [3:0] here);
    if (dest[3:2] > here[3:2])      return DIR_E;
    else if (dest[3:2] < here[3:2]) return DIR_W;
    else if (dest[1:0] > here[1:0]) return DIR_S;
    else if (dest[1:0] < here[1:0]) return DIR_N;
    else                            return DIR_L;
  endfunction

endpackage

// File: rtl/input_port_sync_fifo.sv
// Synchronous FIFO with registered occupancy; head word is read
// combinationally so a pushed entry is visible the cycle after the push.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     push,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_port.sv
// Router input port: buffers link flits, XY-routes the head flit,
// requests the switch and forwards the packet wormhole-style.
module input_port
  import noc_pkg::*;
#(
  parameter logic [3:0]  addr_sw = 4'b0000,
  parameter logic [2:0]  stt     = 3'd5,
  parameter int unsigned DEPTH   = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            flit_in,
  input  logic                   valid_in,
  output logic                   ready_out,
  output logic [2:0]             route_dir,
  output logic                   route_req,
  output logic [2:0]             src_port,
  input  logic                   grant,
  output logic [31:0]            flit_out,
  output logic                   valid_out,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   drop_err
);

  ip_state_t   state, state_next;
  logic        push, pop, full, empty;
  logic        fwd, drop, latch_dir;
  logic [31:0] head_flit;
  flit_type_t  head_type;

  assign src_port  = stt;
  assign ready_out = !rst && !full;
  assign push      = valid_in && ready_out;
  assign head_type = flit_type_t'(head_flit[TYPE_MSB:TYPE_LSB]);

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(FLIT_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_data (flit_in),
    .push    (push),
    .pop     (pop),
    .rd_data (head_flit),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    fwd        = 1'b0;
    drop       = 1'b0;
    latch_dir  = 1'b0;
    case (state)
      ST_IDLE: begin
        if (!empty) begin
          if (head_type == FT_HEAD || head_type == FT_SINGLE) begin
            latch_dir  = 1'b1;
            state_next = ST_REQ;
          end else begin
            pop  = 1'b1;
            drop = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (grant && !empty) begin
          pop        = 1'b1;
          fwd        = 1'b1;
          state_next = (head_type == FT_SINGLE) ? ST_IDLE : ST_FWD;
        end
      end
      ST_FWD: begin
        if (grant && !empty) begin
          pop = 1'b1;
          fwd = 1'b1;
          if (head_type == FT_TAIL) state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      route_req <= 1'b0;
      route_dir <= '0;
      flit_out  <= '0;
      valid_out <= 1'b0;
      drop_err  <= 1'b0;
    end else begin
      state     <= state_next;
      // Rises with entry to REQ, but stays up for one extra cycle after the
      // last flit is popped so it spans the cycle that flit is on flit_out.
      route_req <= (state_next != ST_IDLE) || (state != ST_IDLE);
      if (latch_dir) route_dir <= xy_route(head_flit[DEST_MSB:DEST_LSB], addr_sw);
      valid_out <= fwd;
      if (fwd) flit_out <= head_flit;
      drop_err  <= drop;
    end
  end

endmodule
